// File: rtl/dispatch_tracker.sv
// In-flight slot table between the scheduler stream and the executor: tags and dispatches each
// transaction, collects completions, and emits release records so the conflict checker can unlock.
module dispatch_tracker #(
    parameter int unsigned MAX_DEPENDENCIES = 256,
    parameter int unsigned NUM_SLOTS        = 16,
    parameter int unsigned SLOT_W           = $clog2(NUM_SLOTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [63:0]                 s_axis_tdata_owner_programID,
    input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
    input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [63:0]                 m_axis_tdata_owner_programID,
    output logic [SLOT_W-1:0]           m_axis_tdata_tag,
    input  logic                        cmpl_valid,
    input  logic [SLOT_W-1:0]           cmpl_tag,
    output logic                        rel_valid,
    input  logic                        rel_ready,
    output logic [63:0]                 rel_owner_programID,
    output logic [MAX_DEPENDENCIES-1:0] rel_read_dependencies,
    output logic [MAX_DEPENDENCIES-1:0] rel_write_dependencies,
    output logic [SLOT_W:0]             inflight_count,
    output logic [31:0]                 dispatched_count,
    output logic [31:0]                 released_count,
    output logic [31:0]                 spurious_cmpl,
    output logic                        idle
);

    typedef enum logic [2:0] {StFree, StPend, StExec, StDone, StRelq} slot_state_e;

    slot_state_e                 state_q [NUM_SLOTS];
    slot_state_e                 state_d [NUM_SLOTS];
    logic [63:0]                 id_mem  [NUM_SLOTS];
    logic [MAX_DEPENDENCIES-1:0] rd_mem  [NUM_SLOTS];
    logic [MAX_DEPENDENCIES-1:0] wr_mem  [NUM_SLOTS];

    logic [SLOT_W-1:0] rel_tag_q;
    logic [SLOT_W-1:0] free_idx;
    logic [SLOT_W-1:0] done_idx;
    logic              any_free;
    logic              any_done;
    logic              all_free;
    logic              accept;
    logic              m_hs;
    logic              rel_hs;
    logic              rel_load;
    logic              cmpl_hit;

    // Lowest-index FREE and DONE slots; descending scan leaves the lowest match.
    always_comb begin
        free_idx       = '0;
        done_idx       = '0;
        any_free       = 1'b0;
        any_done       = 1'b0;
        all_free       = 1'b1;
        inflight_count = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (state_q[i] == StFree) begin
                free_idx = SLOT_W'(i);
                any_free = 1'b1;
            end else begin
                all_free       = 1'b0;
                inflight_count = inflight_count + (SLOT_W + 1)'(1);
            end
            if (state_q[i] == StDone) begin
                done_idx = SLOT_W'(i);
                any_done = 1'b1;
            end
        end
    end

    always_comb begin
        s_axis_tready = !rst && any_free && (!m_axis_tvalid || m_axis_tready);
        accept        = s_axis_tvalid && s_axis_tready;
        m_hs          = m_axis_tvalid && m_axis_tready;
        rel_hs        = rel_valid && rel_ready;
        rel_load      = (!rel_valid || rel_ready) && any_done;
        cmpl_hit      = cmpl_valid && (state_q[cmpl_tag] == StExec);
        idle          = all_free && !m_axis_tvalid && !rel_valid;
    end

    // All events touch distinct slots because each requires a different current state.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_d[i] = state_q[i];
        end
        if (accept) begin
            state_d[free_idx] = StPend;
        end
        if (m_hs) begin
            state_d[m_axis_tdata_tag] = StExec;
        end
        if (cmpl_hit) begin
            state_d[cmpl_tag] = StDone;
        end
        if (rel_load) begin
            state_d[done_idx] = StRelq;
        end
        if (rel_hs) begin
            state_d[rel_tag_q] = StFree;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= StFree;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Payload storage needs no reset: slot state gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            id_mem[free_idx] <= s_axis_tdata_owner_programID;
            rd_mem[free_idx] <= s_axis_tdata_read_dependencies;
            wr_mem[free_idx] <= s_axis_tdata_write_dependencies;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid                <= 1'b0;
            m_axis_tdata_owner_programID <= '0;
            m_axis_tdata_tag             <= '0;
        end else if (accept) begin
            m_axis_tvalid                <= 1'b1;
            m_axis_tdata_owner_programID <= s_axis_tdata_owner_programID;
            m_axis_tdata_tag             <= free_idx;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rel_valid              <= 1'b0;
            rel_tag_q              <= '0;
            rel_owner_programID    <= '0;
            rel_read_dependencies  <= '0;
            rel_write_dependencies <= '0;
        end else if (rel_load) begin
            rel_valid              <= 1'b1;
            rel_tag_q              <= done_idx;
            rel_owner_programID    <= id_mem[done_idx];
            rel_read_dependencies  <= rd_mem[done_idx];
            rel_write_dependencies <= wr_mem[done_idx];
        end else if (rel_ready) begin
            rel_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dispatched_count <= '0;
            released_count   <= '0;
            spurious_cmpl    <= '0;
        end else begin
            if (m_hs) begin
                dispatched_count <= dispatched_count + 32'd1;
            end
            if (rel_hs) begin
                released_count <= released_count + 32'd1;
            end
            if (cmpl_valid && !cmpl_hit) begin
                spurious_cmpl <= spurious_cmpl + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_tracker.sv
// Scoreboard bench for dispatch_tracker: directed stimulus pushes expected dispatch and release
// records; a negedge monitor pops and compares them on every handshake.
module tb_dispatch_tracker;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [63:0]  s_id;
    logic [255:0] s_rd;
    logic [255:0] s_wr;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [63:0]  m_id;
    logic [3:0]   m_tag;
    logic         cmpl_valid;
    logic [3:0]   cmpl_tag;
    logic         rel_valid;
    logic         rel_ready;
    logic [63:0]  rel_id;
    logic [255:0] rel_rd;
    logic [255:0] rel_wr;
    logic [4:0]   inflight_count;
    logic [31:0]  dispatched_count;
    logic [31:0]  released_count;
    logic [31:0]  spurious_cmpl;
    logic         idle;

    always #5 clk = ~clk;

    dispatch_tracker dut (
        .clk                            (clk),
        .rst                            (rst),
        .s_axis_tvalid                  (s_axis_tvalid),
        .s_axis_tready                  (s_axis_tready),
        .s_axis_tdata_owner_programID   (s_id),
        .s_axis_tdata_read_dependencies (s_rd),
        .s_axis_tdata_write_dependencies(s_wr),
        .m_axis_tvalid                  (m_axis_tvalid),
        .m_axis_tready                  (m_axis_tready),
        .m_axis_tdata_owner_programID   (m_id),
        .m_axis_tdata_tag               (m_tag),
        .cmpl_valid                     (cmpl_valid),
        .cmpl_tag                       (cmpl_tag),
        .rel_valid                      (rel_valid),
        .rel_ready                      (rel_ready),
        .rel_owner_programID            (rel_id),
        .rel_read_dependencies          (rel_rd),
        .rel_write_dependencies         (rel_wr),
        .inflight_count                 (inflight_count),
        .dispatched_count               (dispatched_count),
        .released_count                 (released_count),
        .spurious_cmpl                  (spurious_cmpl),
        .idle                           (idle)
    );

    typedef struct packed {
        logic [63:0] id;
        logic [3:0]  tag;
    } m_exp_t;

    typedef struct packed {
        logic [63:0]  id;
        logic [255:0] rd;
        logic [255:0] wr;
    } r_exp_t;

    m_exp_t m_q[$];
    r_exp_t r_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] bit_at(input int n);
        logic [255:0] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] id, input logic [255:0] rd, input logic [255:0] wr,
                        input logic [3:0] exp_tag);
        int     n;
        m_exp_t e;
        s_axis_tvalid = 1'b1;
        s_id          = id;
        s_rd          = rd;
        s_wr          = wr;
        n             = 0;
        while (!s_axis_tready && n < 100) begin
            tick();
            n++;
        end
        if (!s_axis_tready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got tready=0 expected tready=1 for id %0h", id);
        end else begin
            e.id  = id;
            e.tag = exp_tag;
            m_q.push_back(e);
            tick();
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic complete(input logic [3:0] tag);
        cmpl_valid = 1'b1;
        cmpl_tag   = tag;
        tick();
        cmpl_valid = 1'b0;
    endtask

    task automatic expect_rel(input logic [63:0] id, input logic [255:0] rd,
                              input logic [255:0] wr);
        r_exp_t e;
        e.id = id;
        e.rd = rd;
        e.wr = wr;
        r_q.push_back(e);
    endtask

    // Monitor: every handshake about to happen at the next rising edge is checked here.
    always @(negedge clk) begin
        m_exp_t me;
        r_exp_t re;
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (m_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL m_unexpected: got id %0h tag %0d expected none", m_id, m_tag);
            end else begin
                me = m_q.pop_front();
                chk("m_id", 256'(m_id), 256'(me.id));
                chk("m_tag", 256'(m_tag), 256'(me.tag));
            end
        end
        if (!rst && rel_valid && rel_ready) begin
            if (r_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rel_unexpected: got id %0h expected none", rel_id);
            end else begin
                re = r_q.pop_front();
                chk("rel_id", 256'(rel_id), 256'(re.id));
                chk("rel_rd", rel_rd, re.rd);
                chk("rel_wr", rel_wr, re.wr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_id          = '0;
        s_rd          = '0;
        s_wr          = '0;
        m_axis_tready = 1'b1;
        cmpl_valid    = 1'b0;
        cmpl_tag      = '0;
        rel_ready     = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_idle", 256'(idle), 256'(1));
        chk("rst_tready", 256'(s_axis_tready), 256'(1));
        chk("rst_inflight", 256'(inflight_count), 256'(0));
        chk("rst_mvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_relvalid", 256'(rel_valid), 256'(0));

        // 1: single transaction end to end
        send(64'h5, bit_at(3), bit_at(7), 4'd0);
        chk("t1_mvalid_lat1", 256'(m_axis_tvalid), 256'(1));
        chk("t1_mtag", 256'(m_tag), 256'(0));
        tick();
        expect_rel(64'h5, bit_at(3), bit_at(7));
        complete(4'd0);
        repeat (4) tick();
        chk("t1_idle", 256'(idle), 256'(1));
        chk("t1_disp", 256'(dispatched_count), 256'(1));
        chk("t1_rel", 256'(released_count), 256'(1));

        // 2: fill all 16 slots, 17th stalls until tag 9 is released
        for (int i = 0; i < 16; i++) begin
            send(64'h100 + 64'(i), bit_at(i), bit_at(i + 100), 4'(i));
        end
        s_axis_tvalid = 1'b1;
        s_id          = 64'h110;
        repeat (2) tick();
        chk("t2_full_tready", 256'(s_axis_tready), 256'(0));
        chk("t2_inflight16", 256'(inflight_count), 256'(16));
        expect_rel(64'h109, bit_at(9), bit_at(109));
        complete(4'd9);
        send(64'h110, bit_at(16), bit_at(116), 4'd9);
        repeat (3) tick();
        chk("t2_disp", 256'(dispatched_count), 256'(18));
        chk("t2_rel", 256'(released_count), 256'(2));

        // 4: two completions, release held while rel_ready is low
        rel_ready = 1'b0;
        expect_rel(64'h104, bit_at(4), bit_at(104));
        complete(4'd4);
        expect_rel(64'h102, bit_at(2), bit_at(102));
        complete(4'd2);
        for (int i = 0; i < 3; i++) begin
            chk("t4_relvalid_hold", 256'(rel_valid), 256'(1));
            chk("t4_relid_hold", 256'(rel_id), 256'(64'h104));
            chk("t4_relrd_hold", rel_rd, bit_at(4));
            tick();
        end
        rel_ready = 1'b1;
        repeat (4) tick();
        chk("t4_rel", 256'(released_count), 256'(4));

        // 3: executor backpressure
        m_axis_tready = 1'b0;
        send(64'h300, bit_at(30), bit_at(130), 4'd2);
        for (int i = 0; i < 5; i++) begin
            chk("t3_mid_stable", 256'(m_id), 256'(64'h300));
            chk("t3_mtag_stable", 256'(m_tag), 256'(2));
            chk("t3_tready_low", 256'(s_axis_tready), 256'(0));
            chk("t3_disp_hold", 256'(dispatched_count), 256'(18));
            tick();
        end
        m_axis_tready = 1'b1;
        repeat (2) tick();
        chk("t3_disp", 256'(dispatched_count), 256'(19));

        // 5: spurious completions (FREE slot, then PEND slot in its dispatch cycle)
        complete(4'd4);
        chk("t5_spur1", 256'(spurious_cmpl), 256'(1));
        m_axis_tready = 1'b0;
        send(64'h400, bit_at(40), bit_at(140), 4'd4);
        m_axis_tready = 1'b1;
        complete(4'd4);
        chk("t5_spur2", 256'(spurious_cmpl), 256'(2));
        repeat (3) tick();
        chk("t5_no_rel", 256'(rel_valid), 256'(0));
        chk("t5_inflight", 256'(inflight_count), 256'(16));
        chk("t5_relcnt", 256'(released_count), 256'(4));

        // 6: reset with work in flight and a release pending
        rel_ready = 1'b0;
        complete(4'd0);
        complete(4'd1);
        repeat (2) tick();
        chk("t6_pre_relvalid", 256'(rel_valid), 256'(1));
        rst = 1'b1;
        tick();
        chk("t6_idle", 256'(idle), 256'(1));
        chk("t6_tready", 256'(s_axis_tready), 256'(0));
        chk("t6_mvalid", 256'(m_axis_tvalid), 256'(0));
        chk("t6_relvalid", 256'(rel_valid), 256'(0));
        chk("t6_relid", 256'(rel_id), 256'(0));
        chk("t6_inflight", 256'(inflight_count), 256'(0));
        chk("t6_disp", 256'(dispatched_count), 256'(0));
        chk("t6_spur", 256'(spurious_cmpl), 256'(0));
        rst       = 1'b0;
        rel_ready = 1'b1;
        tick();
        chk("t6_tready_after", 256'(s_axis_tready), 256'(1));
        repeat (5) tick();
        chk("t6_no_rel", 256'(rel_valid), 256'(0));
        chk("t6_relcnt", 256'(released_count), 256'(0));
        chk("m_queue_empty", 256'(m_q.size()), 256'(0));
        chk("r_queue_empty", 256'(r_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
